sobel_window_buffer: RTL and testbench

SOBEL_WINDOW_BUFFER -- requirements
Module: sobel_window_buffer

---
 rtl/sobel_window_buffer_if.sv | 21 ++
 rtl/sobel_window_buffer.sv | 112 +++++++++++
 tb/tb_sobel_window_buffer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sobel_window_buffer_if.sv
// Pixel-stream bundle between the grayscale stage and the 3x3 window builder.
// The master drives pixels in; the slave returns windows.
interface sobel_window_buffer_if #(
    parameter int PIXEL_WIDTH_OUT = 8
);
    logic                         px_rdy_i;
    logic [PIXEL_WIDTH_OUT-1:0]   in_px_gray_i;
    logic [9*PIXEL_WIDTH_OUT-1:0] win_px_o;
    logic                         px_rdy_o;
    logic                         frame_end_o;

    modport master (
        output px_rdy_i, in_px_gray_i,
        input  win_px_o, px_rdy_o, frame_end_o
    );

    modport slave (
        input  px_rdy_i, in_px_gray_i,
        output win_px_o, px_rdy_o, frame_end_o
    );
endinterface

// File: rtl/sobel_window_buffer.sv
// Builds 3x3 pixel windows from a raster gray stream using two shift-register
// line buffers; emits one window per interior pixel, one cycle after it arrives.
module sobel_window_buffer #(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    sobel_window_buffer_if.slave  bus
);
    localparam int PIXEL_WIDTH_OUT = 8;
    localparam int PW = PIXEL_WIDTH_OUT;
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [PW-1:0]     r_lb1 [IMG_WIDTH];
    logic [PW-1:0]     r_lb2 [IMG_WIDTH];
    logic [PW-1:0]     r_win [3][3];
    logic [PW-1:0]     w_win_next [3][3];
    logic [9*PW-1:0]   w_win_flat;
    logic [9*PW-1:0]   r_win_out;
    logic              r_px_rdy;
    logic              r_frame_end;
    logic              w_accept;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_interior;

    assign w_accept   = bus.px_rdy_i;
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_interior = (r_row >= RW'(2)) && (r_col >= CW'(2));

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Line buffers carry no reset: stale lines are masked until row 2 of a frame.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_lb1[0] <= bus.in_px_gray_i;
            r_lb2[0] <= r_lb1[IMG_WIDTH-1];
            for (int i = 1; i < IMG_WIDTH; i++) begin
                r_lb1[i] <= r_lb1[i-1];
                r_lb2[i] <= r_lb2[i-1];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                w_win_next[r][c] = r_win[r][c+1];
            end
        end
        w_win_next[0][2] = r_lb2[IMG_WIDTH-1];
        w_win_next[1][2] = r_lb1[IMG_WIDTH-1];
        w_win_next[2][2] = bus.in_px_gray_i;
    end

    // Row-major packing: element 0 (top-left) lands in the most significant byte.
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_pack
            assign w_win_flat[(8-gi)*PW +: PW] = w_win_next[gi/3][gi%3];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            r_win <= w_win_next;
        end
    end

    // The visible window only changes when a complete interior window is formed.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            r_win_out   <= '0;
            r_px_rdy    <= 1'b0;
            r_frame_end <= 1'b0;
        end else begin
            r_px_rdy    <= w_accept && w_interior;
            r_frame_end <= w_accept && w_row_last && w_col_last;
            if (w_accept && w_interior) begin
                r_win_out <= w_win_flat;
            end
        end
    end

    assign bus.win_px_o    = r_win_out;
    assign bus.px_rdy_o    = r_px_rdy;
    assign bus.frame_end_o = r_frame_end;
endmodule

// File: tb/tb_sobel_window_buffer.sv
// Scoreboard bench for the 3x3 window builder on a 4x4 image.
module tb_sobel_window_buffer;
    localparam int W = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    logic nreset_i;
    always #5 clk = ~clk;

    sobel_window_buffer_if #(.PIXEL_WIDTH_OUT(8)) bus ();

    sobel_window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk_i    (clk),
        .nreset_i (nreset_i),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;
    int win_cnt  = 0;
    int fe_cnt   = 0;

    logic [7:0]  img [H][W];
    int          mr, mc;
    logic [72:0] q [$];
    logic [71:0] last_win;
    logic        prev_in;

    task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] build_win();
        logic [71:0] w;
        w = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w[(8-(dr*3+dc))*8 +: 8] = img[mr-2+dr][mc-2+dc];
        return w;
    endfunction

    task automatic model_accept(input logic [7:0] p);
        img[mr][mc] = p;
        if (mr >= 2 && mc >= 2)
            q.push_back({((mr == H-1) && (mc == W-1)), build_win()});
        if (mc == W-1) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
        end else begin
            mc = mc + 1;
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] p);
        @(posedge clk);
        #1;
        bus.px_rdy_i     = v;
        bus.in_px_gray_i = p;
        if (v) model_accept(p);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h00);
    endtask

    task automatic send_frame(input logic [7:0] offs, input bit stall);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (stall)
                    while ($urandom_range(0, 2) == 0) drive(1'b0, 8'($urandom));
                drive(1'b1, 8'(r*16 + c) + offs);
            end
    endtask

    task automatic check_phase(input string tag, input int w0, input int f0,
                               input int nwin, input int nfe);
        chk({tag, "_windows"}, 73'(win_cnt - w0), 73'(nwin));
        chk({tag, "_frame_ends"}, 73'(fe_cnt - f0), 73'(nfe));
        chk({tag, "_queue_empty"}, 73'(q.size()), 73'(0));
    endtask

    always @(negedge clk) begin
        logic [72:0] e;
        if (!nreset_i) begin
            chk("rst_outputs", {bus.frame_end_o, bus.win_px_o}, 73'(0));
            chk("rst_rdy", 73'(bus.px_rdy_o), 73'(0));
            last_win = '0;
            prev_in  = 1'b0;
        end else begin
            chk("rdy_after_idle", 73'(bus.px_rdy_o & ~prev_in), 73'(0));
            if (bus.px_rdy_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_window", 73'(1), 73'(0));
                end else begin
                    e = q.pop_front();
                    chk("window", {bus.frame_end_o, bus.win_px_o}, e);
                    $display("window %0d: win=%h frame_end=%0b", win_cnt, bus.win_px_o, bus.frame_end_o);
                    last_win = e[71:0];
                    win_cnt++;
                    if (bus.frame_end_o) fe_cnt++;
                end
            end else begin
                chk("hold", {bus.frame_end_o, bus.win_px_o}, {1'b0, last_win});
            end
            prev_in = bus.px_rdy_i;
        end
    end

    initial begin
        int w0, f0;
        logic [71:0] last_exp;
        last_exp = 72'h11_12_13_21_22_23_31_32_33;
        nreset_i         = 1'b0;
        bus.px_rdy_i     = 1'b0;
        bus.in_px_gray_i = 8'h00;
        mr = 0;
        mc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_win", 73'(bus.win_px_o), 73'(0));
        chk("reset_rdy_fe", 73'({bus.px_rdy_o, bus.frame_end_o}), 73'(0));
        nreset_i = 1'b1;

        // continuous frame
        w0 = win_cnt; f0 = fe_cnt;
        send_frame(8'h00, 1'b0);
        drain();
        check_phase("continuous", w0, f0, 4, 1);
        chk("continuous_last", 73'(bus.win_px_o), 73'(last_exp));

        // random stalls
        w0 = win_cnt; f0 = fe_cnt;
        send_frame(8'h00, 1'b1);
        drain();
        check_phase("stall", w0, f0, 4, 1);
        chk("stall_last", 73'(bus.win_px_o), 73'(last_exp));

        // back-to-back frames, second frame tagged so mixing would show
        w0 = win_cnt; f0 = fe_cnt;
        send_frame(8'h00, 1'b0);
        send_frame(8'h80, 1'b0);
        drain();
        check_phase("b2b", w0, f0, 8, 2);

        // mid-frame reset after pixel 0x21
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++)
                if (r < 2 || c < 2) drive(1'b1, 8'(r*16 + c));
        @(posedge clk);
        #1;
        bus.px_rdy_i = 1'b0;
        nreset_i     = 1'b0;
        mr = 0;
        mc = 0;
        q.delete();
        #1;
        chk("midrst_win", 73'(bus.win_px_o), 73'(0));
        chk("midrst_rdy_fe", 73'({bus.px_rdy_o, bus.frame_end_o}), 73'(0));
        repeat (2) @(posedge clk);
        #1;
        nreset_i = 1'b1;
        w0 = win_cnt; f0 = fe_cnt;
        send_frame(8'h00, 1'b0);
        drain();
        check_phase("after_reset", w0, f0, 4, 1);
        chk("after_reset_last", 73'(bus.win_px_o), 73'(last_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
